// File: rtl/nes_bus_pkg.sv
// Shared types and default address map for the NES-style CPU bus fabric.
// Channel 0 sits in the low 16-bit word of the base/mask vectors.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_RD    = 3'd3,
    DMA_WR    = 3'd4
  } dma_state_e;

  localparam logic [15:0] DMA_REG_DEF  = 16'h4014;
  localparam logic [15:0] DMA_DEST_DEF = 16'h2004;

  // Defaults: RAM, PPU regs, APU/IO, cartridge.
  localparam logic [63:0] SLAVE_BASE_DEF = {16'h8000, 16'h4000, 16'h2000, 16'h0000};
  localparam logic [63:0] SLAVE_MASK_DEF = {16'h8000, 16'hE000, 16'hE000, 16'hE000};

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA sequencer: halts the CPU, optionally burns an alignment cycle,
// then copies 256 bytes from {page, index} as alternating read/write cycles.
module oam_dma
  import nes_bus_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [7:0]  page_in,
  input  logic        odd_or_even,
  output dma_state_e  state,
  output logic        busy,
  output logic [15:0] rd_addr
);

  logic [7:0] page;
  logic [7:0] index;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state <= DMA_IDLE;
      busy  <= 1'b0;
      page  <= 8'h00;
      index <= 8'h00;
    end else begin
      case (state)
        DMA_IDLE: begin
          if (trigger) begin
            page  <= page_in;
            index <= 8'h00;
            state <= DMA_HALT;
            busy  <= 1'b1;
          end
        end
        DMA_HALT:  state <= odd_or_even ? DMA_ALIGN : DMA_RD;
        DMA_ALIGN: state <= DMA_RD;
        DMA_RD:    state <= DMA_WR;
        DMA_WR: begin
          // index wraps to 0 on the final write, ready for the next transfer
          index <= index + 8'd1;
          if (index == 8'hFF) begin
            state <= DMA_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DMA_RD;
          end
        end
        default: begin
          state <= DMA_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr = {page, index};

endmodule

// File: rtl/bus_fabric.sv
// CPU-side bus fabric: mask/match slave decode, registered read-lane select
// with open-bus hold, and bus takeover by the sprite DMA.
module bus_fabric
  import nes_bus_pkg::*;
#(
  parameter int                     N_SLAVES   = 4,
  parameter logic [16*N_SLAVES-1:0] SLAVE_BASE = SLAVE_BASE_DEF,
  parameter logic [16*N_SLAVES-1:0] SLAVE_MASK = SLAVE_MASK_DEF,
  parameter logic [15:0]            DMA_REG    = DMA_REG_DEF,
  parameter logic [15:0]            DMA_DEST   = DMA_DEST_DEF
) (
  input  logic                  cpu_clk,
  input  logic                  reset,
  input  logic                  odd_or_even,
  input  logic [15:0]           cpu_addr,
  input  logic                  cpu_wr_n,
  input  logic [7:0]            cpu_do,
  output logic                  cpu_rdy,
  output logic [7:0]            cpu_di,
  output logic [15:0]           bus_addr,
  output logic                  bus_wr_n,
  output logic [7:0]            bus_dout,
  output logic [N_SLAVES-1:0]   slave_sel,
  input  logic [8*N_SLAVES-1:0] slave_q,
  output logic                  dma_active
);

  dma_state_e          dma_state;
  logic                dma_busy;
  logic [15:0]         dma_addr;
  logic                trigger;
  logic [N_SLAVES-1:0] sel_q;
  logic [7:0]          open_bus;
  logic [7:0]          lane;
  logic [7:0]          rd_data;

  // The CPU is stalled while busy, so a DMA_REG write can only arrive in IDLE.
  assign trigger = !dma_busy && !cpu_wr_n && (cpu_addr == DMA_REG);

  oam_dma u_dma (
    .cpu_clk     (cpu_clk),
    .reset       (reset),
    .trigger     (trigger),
    .page_in     (cpu_do),
    .odd_or_even (odd_or_even),
    .state       (dma_state),
    .busy        (dma_busy),
    .rd_addr     (dma_addr)
  );

  always_comb begin
    bus_addr = cpu_addr;
    bus_wr_n = cpu_wr_n;
    bus_dout = cpu_do;
    if (dma_busy) begin
      if (dma_state == DMA_WR) begin
        bus_addr = DMA_DEST;
        bus_wr_n = 1'b0;
        bus_dout = rd_data;
      end else begin
        // HALT/ALIGN present a harmless read of the first source byte
        bus_addr = dma_addr;
        bus_wr_n = 1'b1;
        bus_dout = 8'h00;
      end
    end
  end

  // Descending scan so the lowest matching channel overrides higher ones.
  always_comb begin
    slave_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((bus_addr & SLAVE_MASK[16*i +: 16]) == SLAVE_BASE[16*i +: 16]) begin
        slave_sel    = '0;
        slave_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    lane = 8'h00;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) lane = slave_q[8*i +: 8];
    end
  end

  assign rd_data = (sel_q == '0) ? open_bus : lane;
  assign cpu_di  = dma_busy ? open_bus : rd_data;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      sel_q    <= '0;
      open_bus <= 8'h00;
    end else begin
      sel_q    <= slave_sel;
      open_bus <= cpu_di;
    end
  end

  assign cpu_rdy    = !dma_busy;
  assign dma_active = dma_busy;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: decode, open bus, DMA timing/data, reset abort.
module tb_bus_fabric;

  logic        cpu_clk = 1'b0;
  logic        reset = 1'b1;
  logic        odd_or_even = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr_n = 1'b1;
  logic [7:0]  cpu_do = 8'h00;

  logic        cpu_rdy, bus_wr_n, dma_active;
  logic [7:0]  cpu_di, bus_dout;
  logic [15:0] bus_addr;
  logic [3:0]  slave_sel;
  logic [31:0] slave_q = '0;

  logic        b_rdy, b_wr_n, b_act;
  logic [7:0]  b_di, b_dout;
  logic [15:0] b_addr;
  logic [1:0]  b_sel;
  logic [15:0] b_q = '0;

  logic        c_rdy, c_wr_n, c_act;
  logic [7:0]  c_di, c_dout;
  logic [15:0] c_addr;
  logic [3:0]  c_sel;

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  always #5 cpu_clk = ~cpu_clk;

  bus_fabric u_dut (
    .cpu_clk(cpu_clk), .reset(reset), .odd_or_even(odd_or_even),
    .cpu_addr(cpu_addr), .cpu_wr_n(cpu_wr_n), .cpu_do(cpu_do),
    .cpu_rdy(cpu_rdy), .cpu_di(cpu_di), .bus_addr(bus_addr),
    .bus_wr_n(bus_wr_n), .bus_dout(bus_dout), .slave_sel(slave_sel),
    .slave_q(slave_q), .dma_active(dma_active)
  );

  bus_fabric #(
    .N_SLAVES(2), .SLAVE_BASE(32'h2000_0000), .SLAVE_MASK(32'hE000_E000)
  ) u_dut2 (
    .cpu_clk(cpu_clk), .reset(reset), .odd_or_even(odd_or_even),
    .cpu_addr(cpu_addr), .cpu_wr_n(cpu_wr_n), .cpu_do(cpu_do),
    .cpu_rdy(b_rdy), .cpu_di(b_di), .bus_addr(b_addr),
    .bus_wr_n(b_wr_n), .bus_dout(b_dout), .slave_sel(b_sel),
    .slave_q(b_q), .dma_active(b_act)
  );

  // Channel 1 overlaps channel 3 in the A000-BFFF window.
  bus_fabric #(
    .N_SLAVES(4), .SLAVE_BASE(64'h8000_4000_A000_0000)
  ) u_dut3 (
    .cpu_clk(cpu_clk), .reset(reset), .odd_or_even(odd_or_even),
    .cpu_addr(cpu_addr), .cpu_wr_n(cpu_wr_n), .cpu_do(cpu_do),
    .cpu_rdy(c_rdy), .cpu_di(c_di), .bus_addr(c_addr),
    .bus_wr_n(c_wr_n), .bus_dout(c_dout), .slave_sel(c_sel),
    .slave_q(32'h0), .dma_active(c_act)
  );

  // Slave memory model: every lane answers one cycle after the address.
  function automatic logic [7:0] slv(input int i, input logic [15:0] a);
    return a[7:0] ^ 8'hA0 ^ (8'(i) << 4);
  endfunction

  // Expected read data under the default map, written out by hand.
  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    logic [7:0] key;
    if (a[15])                  key = 8'h30;
    else if (a[15:13] == 3'b010) key = 8'h20;
    else if (a[15:13] == 3'b001) key = 8'h10;
    else                         key = 8'h00;
    return a[7:0] ^ 8'hA0 ^ key;
  endfunction

  always @(posedge cpu_clk) begin
    for (int i = 0; i < 4; i++) slave_q[8*i +: 8] <= slv(i, bus_addr);
    for (int i = 0; i < 2; i++) b_q[8*i +: 8] <= slv(i, b_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [3:0] es, input logic [7:0] ed);
    cpu_addr = a;
    cpu_wr_n = 1'b1;
    @(negedge cpu_clk);
    chk("rd_sel", 32'(slave_sel), 32'(es));
    step();
    @(negedge cpu_clk);
    chk("rd_di", 32'(cpu_di), 32'(ed));
    step();
  endtask

  task automatic rd2(input logic [15:0] a, input logic [1:0] es, input logic [7:0] ed);
    cpu_addr = a;
    cpu_wr_n = 1'b1;
    @(negedge cpu_clk);
    chk("n2_sel", 32'(b_sel), 32'(es));
    step();
    @(negedge cpu_clk);
    chk("n2_di", 32'(b_di), 32'(ed));
    step();
  endtask

  task automatic dma_xfer(input logic [7:0] pg, input logic odd, input bit poke,
                          input int exp_stall);
    int stall;
    int nwr;
    logic [15:0] prev_addr;
    logic [15:0] a;
    logic [23:0] e;
    for (int k = 0; k < 256; k++) begin
      a = {pg, 8'(k)};
      exp_q.push_back({a, exp_rd(a)});
    end
    cpu_addr = 16'h4014;
    cpu_wr_n = 1'b0;
    cpu_do = pg;
    odd_or_even = odd;
    @(negedge cpu_clk);
    chk("dma_trig_addr", 32'(bus_addr), 32'h4014);
    chk("dma_trig_wr_n", 32'(bus_wr_n), 32'h0);
    chk("dma_trig_dout", 32'(bus_dout), 32'(pg));
    step();
    cpu_addr = 16'h0000;
    cpu_wr_n = 1'b1;
    cpu_do = 8'h00;
    stall = 0;
    nwr = 0;
    prev_addr = '0;
    for (int c = 0; c < 700; c++) begin
      @(negedge cpu_clk);
      if (cpu_rdy) break;
      stall++;
      chk("dma_active", 32'(dma_active), 32'h1);
      if (!bus_wr_n) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hFFFFFF;
        chk("dma_wr_addr", 32'(bus_addr), 32'h2004);
        chk("dma_rd_addr", 32'(prev_addr), 32'(e[23:8]));
        chk("dma_wr_data", 32'(bus_dout), 32'(e[7:0]));
        nwr++;
      end
      prev_addr = bus_addr;
      if (poke && stall == 10) begin
        cpu_addr = 16'h4014; cpu_wr_n = 1'b0; cpu_do = 8'h55;
      end
      if (poke && stall == 12) begin
        cpu_addr = 16'h0000; cpu_wr_n = 1'b1; cpu_do = 8'h00;
      end
    end
    chk("dma_stall", 32'(stall), 32'(exp_stall));
    chk("dma_writes", 32'(nwr), 32'd256);
    chk("dma_done_active", 32'(dma_active), 32'h0);
    exp_q.delete();
    odd_or_even = 1'b0;
    step();
  endtask

  initial begin
    int nwr;
    // clock/reset
    step();
    step();
    @(negedge cpu_clk);
    chk("rst_cpu_rdy", 32'(cpu_rdy), 32'h1);
    chk("rst_dma_active", 32'(dma_active), 32'h0);
    chk("rst_cpu_di", 32'(cpu_di), 32'h00);
    step();
    reset = 1'b0;
    step();
    @(negedge cpu_clk);
    chk("idle_pass_addr", 32'(bus_addr), 32'h0000);
    step();

    rd(16'h0005, 4'b0001, 8'hA5);

    cpu_addr = 16'h4003; cpu_wr_n = 1'b0; cpu_do = 8'h5A;
    @(negedge cpu_clk);
    chk("wr_addr", 32'(bus_addr), 32'h4003);
    chk("wr_wr_n", 32'(bus_wr_n), 32'h0);
    chk("wr_dout", 32'(bus_dout), 32'h5A);
    chk("wr_sel", 32'(slave_sel), 32'b0100);
    step();
    cpu_wr_n = 1'b1; cpu_do = 8'h00;

    rd(16'h8123, 4'b1000, 8'hB3);
    rd(16'h6000, 4'b0000, 8'hB3);

    cpu_addr = 16'hA000;
    @(negedge cpu_clk);
    chk("ovl_default_sel", 32'(slave_sel), 32'b1000);
    chk("ovl_lowest_sel", 32'(c_sel), 32'b0010);
    step();

    rd2(16'h009C, 2'b01, 8'h3C);
    rd2(16'h6000, 2'b00, 8'h3C);

    dma_xfer(8'h02, 1'b0, 1'b1, 513);
    dma_xfer(8'h02, 1'b1, 1'b0, 514);
    dma_xfer(8'h21, 1'b0, 1'b0, 513);

    // abort mid-transfer
    cpu_addr = 16'h4014; cpu_wr_n = 1'b0; cpu_do = 8'h02;
    step();
    cpu_addr = 16'h0000; cpu_wr_n = 1'b1; cpu_do = 8'h00;
    repeat (100) @(negedge cpu_clk);
    chk("abort_pre_active", 32'(dma_active), 32'h1);
    #3 reset = 1'b1;
    #1;
    chk("abort_dma_active", 32'(dma_active), 32'h0);
    chk("abort_cpu_rdy", 32'(cpu_rdy), 32'h1);
    chk("abort_cpu_di", 32'(cpu_di), 32'h00);
    step();
    step();
    reset = 1'b0;
    cpu_addr = 16'h0123;
    nwr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge cpu_clk);
      if (!bus_wr_n) nwr++;
    end
    chk("abort_no_wr", 32'(nwr), 32'h0);
    chk("abort_pass_addr", 32'(bus_addr), 32'h0123);
    chk("abort_cpu_rdy_after", 32'(cpu_rdy), 32'h1);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4: number of decoded slave channels (1..8).
REQ-002 SHALL have parameter SLAVE_BASE, default {16'h8000,16'h4000,16'h2000,16'h0000}: per-channel match value, channel 0 in the low word.
REQ-003 SHALL have parameter SLAVE_MASK, default {16'h8000,16'hE000,16'hE000,16'hE000}: per-channel match mask.
REQ-004 SHALL have parameter DMA_REG, default 16'h4014: address of the DMA page register.
REQ-005 SHALL have parameter DMA_DEST, default 16'h2004: DMA write target address.
REQ-006 cpu_clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 odd_or_even  in  1  CPU cycle parity; 1 = odd cycle.
REQ-009 cpu_addr  in  16  CPU address.
REQ-010 cpu_wr_n  in  1  CPU R/W; 1 = read, 0 = write.
REQ-011 cpu_do  in  8  CPU write data.
REQ-012 cpu_rdy  out  1  CPU ready; 0 stalls the CPU.
REQ-013 cpu_di  out  8  read data returned to the CPU.
REQ-014 bus_addr  out  16  address presented to slaves.
REQ-015 bus_wr_n  out  1  slave R/W, same polarity as cpu_wr_n.
REQ-016 bus_dout  out  8  write data to slaves.
REQ-017 slave_sel  out  N_SLAVES  one-hot slave select for the current bus_addr.
REQ-018 slave_q  in  8*N_SLAVES  slave read data, channel i at [8i+7:8i]; 1-cycle synchronous latency.
REQ-019 dma_active  out  1  high while a DMA transfer owns the bus.

Function
REQ-020 Channel i SHALL match when (bus_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]; lowest matching index wins; no match SHALL drive slave_sel = 0.
REQ-021 When idle, bus_addr/bus_wr_n/bus_dout SHALL pass cpu_addr/cpu_wr_n/cpu_do combinationally.
REQ-022 The select SHALL be registered each cycle; cpu_di SHALL be the slave_q lane of the registered select, one cycle after the address.
REQ-023 If the registered select is empty, cpu_di SHALL return the open-bus latch, which holds the last value driven on cpu_di.
REQ-024 A CPU write to DMA_REG SHALL be forwarded to the bus and SHALL latch cpu_do as the page; the DMA SHALL start on the next cycle.
REQ-025 DMA FSM states SHALL be IDLE, HALT, ALIGN, RD, WR; IDLE->HALT on trigger; HALT->ALIGN if odd_or_even=1, else HALT->RD; ALIGN->RD; RD->WR; WR->RD while the 8-bit index is not 255; WR->IDLE after index 255.
REQ-026 The total stall SHALL be 513 cycles when starting on an even cycle and 514 when starting on an odd cycle.
REQ-027 In RD, bus_addr SHALL be {page, index} with bus_wr_n=1; in WR, bus_addr SHALL be DMA_DEST with bus_wr_n=0 and bus_dout = slave_q lane of the RD cycle's select.
REQ-028 The index SHALL reset to 0 at trigger, increment after each WR, and wrap 255->0 at completion.
REQ-029 cpu_rdy SHALL be 0 and dma_active SHALL be 1 in every state except IDLE; the CPU bus SHALL be ignored and cpu_di held during these states.
REQ-030 A write to DMA_REG while dma_active SHALL be impossible (CPU stalled); if presented, it SHALL be ignored.
REQ-031 Page 8'h20-8'h3F SHALL be transferred without special-casing; decode follows REQ-020.

Reset
REQ-032 On reset, the FSM SHALL enter IDLE, with index=0, page=0, registered select=0, open-bus latch=8'h00, cpu_rdy=1, dma_active=0, and cpu_di=8'h00.
REQ-033 Reset asserted mid-DMA SHALL abort immediately; no further WR cycles SHALL occur and the CPU pass-through SHALL resume on the first edge after release.

Structure
REQ-034 The DMA state enum, DMA_REG/DMA_DEST defaults and the default base/mask vectors SHALL live in shared package nes_bus_pkg.
REQ-035 The DMA FSM SHALL be one sub-module, oam_dma, instantiated by bus_fabric.

Verification
REQ-036 Read 16'h0005 with slave 0 q=8'hA5 -> slave_sel=4'b0001; cpu_di=8'hA5 one cycle later.
REQ-037 Read unmapped address with N_SLAVES=2 after reading 8'h3C -> slave_sel=0; cpu_di=8'h3C (open bus).
REQ-038 Write 8'h02 to 16'h4014 on an even cycle -> cpu_rdy low for 513 cycles; 256 writes to 16'h2004 carrying slave 0 data from 16'h0200-16'h02FF in order.
REQ-039 Same trigger on an odd cycle -> 514-cycle stall; first RD address is 16'h0200.
REQ-040 Assert reset after 100 DMA cycles -> dma_active=0, cpu_rdy=1 asynchronously; no bus_wr_n=0 cycle follows.
REQ-041 Address 16'hA000 with overlapping masks for channels 1 and 3 -> lowest index selected.
